pipe_stall_ctrl: RTL

Pipeline stall/flush controller sitting between the hazard detection logic in ID and the pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM). It turns one-cycle hazard requests (RAW, memory wait, branch flush) into the per-stage `PAUSE_ENABLE`/`PAUSE_DISABLE` hold, bubble and flush strobes. It also sequences multi-cycle RAW stalls with an internal countdown, so the hazard detector only has to flag the hazard once.

---
 rtl/pipe_stall_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns one-cycle hazard requests into per-stage hold/bubble/flush strobes.
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             raw_req,
   input  logic [CNT_W-1:0] raw_cycles,
   input  logic             mem_busy,
   input  logic             flush_req,
   output logic             pc_pause,
   output logic             if_id_pause,
   output logic             id_exe_pause,
   output logic             exe_mem_pause,
   output logic             id_exe_bubble,
   output logic             if_id_flush,
   output logic             stall_busy
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [15:0]      perf_stall_cnt
`endif
);

   localparam logic PAUSE_ENABLE  = 1'b1;
   localparam logic PAUSE_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAW_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             ret_raw_r, ret_raw_s;
   logic             flush_pend_r, flush_pend_s;

   logic             flush_s;
   logic             raw_act_s;
   logic [CNT_W-1:0] raw_n_s;

   assign flush_s = flush_pend_r | flush_req;
   assign raw_n_s = (raw_cycles == {CNT_W{1'b0}}) ? CNT_W'(1) : raw_cycles;
   // RAW stall strobes: new hazard in IDLE, ongoing countdown, or resuming after a memory wait
   assign raw_act_s = ~mem_busy & ~flush_s &
                      (((state_r == IDLE) & raw_req) | (state_r == RAW_WAIT) |
                       ((state_r == MEM_WAIT) & ret_raw_r));

   // State and bookkeeping registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         ret_raw_r    <= 1'b0;
         flush_pend_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         ret_raw_r    <= ret_raw_s;
         flush_pend_r <= flush_pend_s;
      end
   end

   // Next-state logic: memory wait beats flush, flush beats RAW
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      ret_raw_s    = ret_raw_r;
      flush_pend_s = flush_pend_r;
      if (mem_busy) begin
         state_s      = MEM_WAIT;
         ret_raw_s    = (state_r == RAW_WAIT) | ((state_r == MEM_WAIT) & ret_raw_r);
         flush_pend_s = flush_pend_r | flush_req;
      end else begin
         ret_raw_s    = 1'b0;
         flush_pend_s = 1'b0;
         if (flush_s) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  if (raw_req) begin
                     cnt_s   = raw_n_s - CNT_W'(1);
                     state_s = (raw_n_s > CNT_W'(1)) ? RAW_WAIT : IDLE;
                  end else begin
                     state_s = IDLE;
                  end
               end
               RAW_WAIT: begin
                  cnt_s   = cnt_r - CNT_W'(1);
                  state_s = (cnt_r == CNT_W'(1)) ? IDLE : RAW_WAIT;
               end
               MEM_WAIT: begin
                  if (ret_raw_r) begin
                     cnt_s   = cnt_r - CNT_W'(1);
                     state_s = (cnt_r == CNT_W'(1)) ? IDLE : RAW_WAIT;
                  end else begin
                     state_s = IDLE;
                  end
               end
               default: begin
                  state_s = IDLE;
                  cnt_s   = {CNT_W{1'b0}};
               end
            endcase
         end
      end
   end

   // Output decode; reset forces everything low without waiting for a clock edge
   always_comb begin
      pc_pause      = PAUSE_DISABLE;
      if_id_pause   = PAUSE_DISABLE;
      id_exe_pause  = PAUSE_DISABLE;
      exe_mem_pause = PAUSE_DISABLE;
      id_exe_bubble = 1'b0;
      if_id_flush   = 1'b0;
      stall_busy    = 1'b0;
      if (rst) begin
         stall_busy = 1'b0;
      end else begin
         stall_busy = (state_r != IDLE);
         if (mem_busy) begin
            pc_pause      = PAUSE_ENABLE;
            if_id_pause   = PAUSE_ENABLE;
            id_exe_pause  = PAUSE_ENABLE;
            exe_mem_pause = PAUSE_ENABLE;
         end else if (flush_s) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
         end else if (raw_act_s) begin
            pc_pause      = PAUSE_ENABLE;
            if_id_pause   = PAUSE_ENABLE;
            id_exe_bubble = 1'b1;
         end else begin
            id_exe_bubble = 1'b0;
         end
      end
   end

`ifdef STALL_PERF_CNT_EN
   // Saturating count of cycles with the PC held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= 16'd0;
      end else if (pc_pause && (perf_stall_cnt != 16'hFFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end else begin
         perf_stall_cnt <= perf_stall_cnt;
      end
   end
`endif

endmodule
